// File: rtl/op_accum_unit.sv
// op_accum_unit: multi-lane select, per-beat unary op, and modular accumulation
// over a programmed beat count. The final sum is offered on a valid/ready port.
module op_accum_unit #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int SEL_W     = $clog2(CHANNELS),
   parameter int ACC_WIDTH = WIDTH * 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [7:0]                 count,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHANNELS*WIDTH-1:0]  data_in,
   input  logic [SEL_W-1:0]           sel,
   input  logic [1:0]                 op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_WIDTH-1:0]       acc_out,
   output logic                       ovf,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ACC_WIDTH-1:0]   acc;
   logic [7:0]             remaining;
   logic                   ovf_flag;

   logic [WIDTH-1:0]       lane [CHANNELS];
   logic [WIDTH-1:0]       x;
   logic [WIDTH-1:0]       op_res;
   logic [ACC_WIDTH:0]     sum;
   logic                   beat;

   // Unpack the lane bus into an indexable array.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign lane[gi] = data_in[gi*WIDTH +: WIDTH];
   end

   // Lane mux; a select beyond the last lane yields a zero operand.
   always_comb begin
      x = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) x = lane[k];
      end
   end

   // Per-beat unary operation at lane width, then widened add with carry-out.
   always_comb begin
      case (op)
         2'd0:    op_res = x;
         2'd1:    op_res = ~x;
         2'd2:    op_res = x + WIDTH'(1);
         default: op_res = '0;
      endcase
      sum  = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, op_res};
      beat = in_valid && in_ready;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (count == 8'd0) ? DONE : ACCUM;
         ACCUM:   if (beat && remaining == 8'd1) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Accumulator, beat counter and sticky wrap flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         remaining <= '0;
         ovf_flag  <= 1'b0;
      end else if (state == IDLE && start) begin
         acc       <= '0;
         remaining <= count;
         ovf_flag  <= 1'b0;
      end else if (beat) begin
         acc       <= sum[ACC_WIDTH-1:0];
         remaining <= remaining - 8'd1;
         ovf_flag  <= ovf_flag | sum[ACC_WIDTH];
      end
   end

   // Outputs decoded from state; the result is the live accumulator.
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      acc_out   = acc;
      ovf       = ovf_flag;
   end

endmodule

// File: tb/tb_op_accum_unit.sv
// Directed bench for op_accum_unit: default instance, a 9-bit accumulator
// instance sharing its inputs, and a five-lane instance for select range.
module tb_op_accum_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   // Shared stimulus for u0 / u1
   logic        start = 1'b0;
   logic [7:0]  count = 8'd0;
   logic        in_valid = 1'b0;
   logic [31:0] data_in = 32'd0;
   logic [1:0]  sel = 2'd0;
   logic [1:0]  op = 2'd0;
   logic        out_ready = 1'b0;

   logic        in_ready0, out_valid0, ovf0, busy0;
   logic [15:0] acc_out0;
   logic        in_ready1, out_valid1, ovf1, busy1;
   logic [8:0]  acc_out1;

   // Stimulus for the five-lane instance
   logic        start2 = 1'b0;
   logic [7:0]  count2 = 8'd0;
   logic        in_valid2 = 1'b0;
   logic [39:0] data_in2 = 40'd0;
   logic [2:0]  sel2 = 3'd0;
   logic [1:0]  op2 = 2'd0;
   logic        out_ready2 = 1'b0;
   logic        in_ready2, out_valid2, ovf2, busy2;
   logic [15:0] acc_out2;

   always #5 clk = ~clk;

   op_accum_unit u0 (
      .clk(clk), .rst(rst), .start(start), .count(count), .in_valid(in_valid),
      .in_ready(in_ready0), .data_in(data_in), .sel(sel), .op(op),
      .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc_out0),
      .ovf(ovf0), .busy(busy0)
   );

   op_accum_unit #(.ACC_WIDTH(9)) u1 (
      .clk(clk), .rst(rst), .start(start), .count(count), .in_valid(in_valid),
      .in_ready(in_ready1), .data_in(data_in), .sel(sel), .op(op),
      .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc_out1),
      .ovf(ovf1), .busy(busy1)
   );

   op_accum_unit #(.CHANNELS(5)) u2 (
      .clk(clk), .rst(rst), .start(start2), .count(count2), .in_valid(in_valid2),
      .in_ready(in_ready2), .data_in(data_in2), .sel(sel2), .op(op2),
      .out_valid(out_valid2), .out_ready(out_ready2), .acc_out(acc_out2),
      .ovf(ovf2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset state ----
      #2;
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
      check("rst_acc", {16'd0, acc_out0}, 32'd0);
      check("rst_ovf", {31'd0, ovf0}, 32'd0);
      #20 rst = 1'b1;
      step();

      // ---- basic sum: 10 + 21 + 240 = 271 ----
      data_in = {8'h0F, 8'd20, 8'd0, 8'd10};
      start = 1'b1; count = 8'd3;
      step();
      start = 1'b0;
      check("basic_busy", {31'd0, busy0}, 32'd1);
      check("basic_in_ready", {31'd0, in_ready0}, 32'd1);
      in_valid = 1'b1; sel = 2'd0; op = 2'd0;
      step();
      sel = 2'd2; op = 2'd2;
      step();
      sel = 2'd3; op = 2'd1;
      check("basic_not_done_yet", {31'd0, out_valid0}, 32'd0);
      step();
      in_valid = 1'b0;
      check("basic_out_valid", {31'd0, out_valid0}, 32'd1);
      check("basic_acc", {16'd0, acc_out0}, 32'd271);
      check("basic_ovf", {31'd0, ovf0}, 32'd0);
      check("basic_in_ready_off", {31'd0, in_ready0}, 32'd0);
      $display("txn basic: acc_out=%0d ovf=%0d", acc_out0, ovf0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("basic_hs_valid", {31'd0, out_valid0}, 32'd0);
      check("basic_hs_busy", {31'd0, busy0}, 32'd0);

      // ---- overflow: 255 beats of ~0x00 ----
      data_in = 32'd0;
      start = 1'b1; count = 8'd255;
      step();
      start = 1'b0;
      in_valid = 1'b1; sel = 2'd1; op = 2'd1;
      repeat (255) step();
      in_valid = 1'b0;
      check("ovf16_valid", {31'd0, out_valid0}, 32'd1);
      check("ovf16_acc", {16'd0, acc_out0}, 32'd65025);
      check("ovf16_flag", {31'd0, ovf0}, 32'd0);
      check("ovf9_valid", {31'd0, out_valid1}, 32'd1);
      check("ovf9_acc", {23'd0, acc_out1}, 32'd1);
      check("ovf9_flag", {31'd0, ovf1}, 32'd1);
      $display("txn overflow: acc16=%0d ovf16=%0d acc9=%0d ovf9=%0d", acc_out0, ovf0, acc_out1, ovf1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // ---- zero count with backpressure; start in DONE ignored ----
      start = 1'b1; count = 8'd0;
      step();
      start = 1'b0;
      check("zero_valid", {31'd0, out_valid0}, 32'd1);
      check("zero_acc", {16'd0, acc_out0}, 32'd0);
      check("zero_ovf9_cleared", {31'd0, ovf1}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2); count = 8'd5;
         step();
         check("bp_valid", {31'd0, out_valid0}, 32'd1);
         check("bp_acc", {16'd0, acc_out0}, 32'd0);
         check("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      end
      start = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("zero_hs_busy", {31'd0, busy0}, 32'd0);
      $display("txn zero_count: acc_out=%0d after 5 stalled cycles", acc_out0);

      // ---- stalls and out-of-range select on five-lane instance ----
      data_in2 = {8'd4, 8'd7, 8'd0, 8'd3, 8'd0};
      start2 = 1'b1; count2 = 8'd2;
      step();
      start2 = 1'b0;
      in_valid2 = 1'b1; sel2 = 3'd3; op2 = 2'd2;
      step();
      in_valid2 = 1'b0;
      check("stall_first_acc", {16'd0, acc_out2}, 32'd8);
      check("stall_in_ready", {31'd0, in_ready2}, 32'd1);
      step();
      check("stall_gap1_acc", {16'd0, acc_out2}, 32'd8);
      check("stall_gap1_valid", {31'd0, out_valid2}, 32'd0);
      step();
      check("stall_gap2_acc", {16'd0, acc_out2}, 32'd8);
      check("stall_gap2_valid", {31'd0, out_valid2}, 32'd0);
      in_valid2 = 1'b1; sel2 = 3'd5; op2 = 2'd0;
      step();
      in_valid2 = 1'b0;
      check("stall_valid", {31'd0, out_valid2}, 32'd1);
      check("stall_acc", {16'd0, acc_out2}, 32'd8);
      check("stall_ovf", {31'd0, ovf2}, 32'd0);
      $display("txn stall_sel: acc_out=%0d", acc_out2);
      out_ready2 = 1'b1;
      step();
      out_ready2 = 1'b0;
      check("stall_hs_busy", {31'd0, busy2}, 32'd0);

      // ---- asynchronous reset mid-run ----
      data_in = {8'd0, 8'd0, 8'd0, 8'd9};
      start = 1'b1; count = 8'd4;
      step();
      start = 1'b0;
      in_valid = 1'b1; sel = 2'd0; op = 2'd0;
      step();
      step();
      in_valid = 1'b0;
      check("mid_acc_before_rst", {16'd0, acc_out0}, 32'd18);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy0}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready0}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid0}, 32'd0);
      check("mid_rst_acc", {16'd0, acc_out0}, 32'd0);
      check("mid_rst_ovf", {31'd0, ovf0}, 32'd0);
      #2 rst = 1'b1;
      step();
      check("post_rst_idle", {31'd0, busy0}, 32'd0);
      start = 1'b1; count = 8'd1;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("post_rst_valid", {31'd0, out_valid0}, 32'd1);
      check("post_rst_acc", {16'd0, acc_out0}, 32'd9);
      $display("txn reset_rerun: acc_out=%0d", acc_out0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_rst_hs_busy", {31'd0, busy0}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/op_accum_unit.md
# op_accum_unit

Parametrised, multi-channel successor to the single-channel operand-select datapath. Each accepted input beat selects one of `CHANNELS` packed input lanes, applies a per-beat unary operation, and accumulates the result over a programmed number of beats. The final sum is presented on a valid/ready output port. The block sits between the channel front-end and the results collector.

## Interface
Parameters:
- `WIDTH`, 8: lane width in bits.
- `CHANNELS`, 4: number of input lanes; must be ≥ 2.
- `SEL_W`, `$clog2(CHANNELS)`: lane-select width (derived; do not override).
- `ACC_WIDTH`, `WIDTH*2`: accumulator and result width; must be > `WIDTH`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `count` input 8: number of beats in the run; sampled with `start`.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts a beat.
- `data_in` input `CHANNELS*WIDTH`: packed lanes; lane k is `data_in[k*WIDTH +: WIDTH]`.
- `sel` input `SEL_W`: lane select for the beat.
- `op` input 2: per-beat operation.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `acc_out` output `ACC_WIDTH`: accumulated result.
- `ovf` output 1: accumulator wrapped during the current run (sticky).
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: on `start`=1 with `count`≠0, latch `count` into `remaining`, clear `acc` and `ovf`, then go to ACCUM.
  - IDLE: on `start`=1 with `count`=0, clear `acc` and `ovf`, then go directly to DONE.
  - ACCUM: `in_ready`=1. A beat is accepted when `in_valid && in_ready`. Each accepted beat decrements `remaining`. When the beat with `remaining`=1 is accepted, go to DONE.
  - DONE: `out_valid`=1. When `out_valid && out_ready`, return to IDLE.
- `start` is ignored outside IDLE. `in_ready`=0 in IDLE and DONE.
- Operand for a beat: `x` = lane `sel`. If `sel` ≥ `CHANNELS`, `x` = 0.
- Operation, computed at `WIDTH` bits:
  - op 0: `x`.
  - op 1: `~x`.
  - op 2: `x+1` mod 2^`WIDTH`.
  - op 3: 0.
- The operation result is zero-extended to `ACC_WIDTH` and added to `acc` modulo 2^`ACC_WIDTH`.
- On carry-out of that addition, `ovf` is set. It stays set until the next accepted `start`.
- `acc_out` is driven from `acc` at all times. It is meaningful only while `out_valid`=1 and holds stable throughout DONE.
- Reset values: state IDLE, `acc`=0, `remaining`=0, `in_ready`=0, `out_valid`=0, `acc_out`=0, `ovf`=0, `busy`=0.

## Timing
- `start` accepted at edge t: `busy`=1 and `in_ready`=1 from t+1.
- One beat per cycle maximum. With `in_valid` held high, N beats are accepted at edges t+1 through t+N.
- Last beat accepted at edge T: `out_valid`=1 and `acc_out` final from T+1 (one-cycle latency). `in_ready`=0 from T+1.
- `start` with `count`=0 at edge t: `out_valid`=1 with `acc_out`=0 from t+1.
- `out_valid` is held until the handshake. Handshake at edge T: `out_valid`=0 and `busy`=0 from T+1. A new `start` can be accepted at T+1 or later (no same-cycle restart).
- `in_valid` gaps stall the run. `remaining` and `acc` hold during stalls.
- An `rst` assertion at any point returns all state to reset values immediately, without waiting for `clk`. A partial run is discarded.

## Test plan
- Basic sum: `WIDTH`=8, `CHANNELS`=4, `count`=3; beats (`sel`,`op`,lane value) = (0,0,10), (2,2,20), (3,1,0x0F) → `acc_out`=10+21+240=271 (0x10F), `ovf`=0, `out_valid` one cycle after the third beat.
- Overflow: `count`=255, every beat op 1 on lane value 0x00 (operand 255) → `acc_out` = 255·255 mod 65536 = 65025, `ovf`=0. Repeat with `ACC_WIDTH`=9 → `acc_out` = 65025 mod 512 = 1 and `ovf`=1.
- Zero count and backpressure: `start` with `count`=0 → `out_valid` next cycle with `acc_out`=0. Hold `out_ready`=0 for 5 cycles → `out_valid` and `acc_out` stay stable; `start` pulsed during DONE is ignored.
- Stalls and invalid select: `count`=2 with `in_valid` toggling 1,0,0,1. Beats are `sel`=3 (lane value 7, op 2) and `sel`=5 with `CHANNELS`=5, `SEL_W`=3 (operand 0) → `acc_out`=8. Verify no beat is accepted in gap cycles.
- Reset mid-run: assert `rst` low after 2 of 4 beats → all outputs 0 and state IDLE immediately. After release, a fresh run of `count`=1 on lane value 9, op 0 → `acc_out`=9.
